// File: rtl/serial_link_txrx_if.sv
// rtl/serial_link_txrx_if.sv - Tx/Rx handshake and serial-line bundle for serial_link_txrx
interface serial_link_txrx_if #(
    parameter int WIDTH = 8
);
    logic             Send;
    logic [WIDTH-1:0] PDin;
    logic             TxBusy;
    logic             SCout;
    logic             SDout;
    logic             SCin;
    logic             SDin;
    logic [WIDTH-1:0] PDout;
    logic             ready;
    logic             ParErr;
    logic             FrmErr;

    modport master (
        output Send, PDin, SCin, SDin,
        input  TxBusy, SCout, SDout, PDout, ready, ParErr, FrmErr
    );

    modport slave (
        input  Send, PDin, SCin, SDin,
        output TxBusy, SCout, SDout, PDout, ready, ParErr, FrmErr
    );
endinterface

// File: rtl/serial_link_txrx.sv
// rtl/serial_link_txrx.sv - framed clocked-serial transmitter and receiver with parity/framing checks
module serial_link_txrx #(
    parameter int WIDTH      = 8,
    parameter int CLK_DIV    = 4,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              Clk,
    input  logic              Rst,
    serial_link_txrx_if.slave bus
);
    localparam int NB    = WIDTH + 2 + PARITY_EN;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TXC_W = $clog2(NB);
    localparam int RXC_W = $clog2(WIDTH + PARITY_EN + 1);
    localparam logic ODD = (PARITY_ODD != 0);

    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
    typedef enum logic {RX_IDLE, RX_RECV}  rx_state_t;

    tx_state_t        tx_state_q;
    logic [DIV_W-1:0] div_q;
    logic [TXC_W-1:0] bit_q;
    logic             sc_q;
    logic             sd_q;
    logic             busy_q;
    logic [NB-2:0]    tx_sh_q;
    logic [NB-2:0]    tx_frame_d;

    // Bits following the start bit: data LSB first, optional parity, stop; fill of 1s is the stop.
    always_comb begin
        tx_frame_d              = '1;
        tx_frame_d[WIDTH-1:0]   = bus.PDin;
        if (PARITY_EN != 0) begin
            tx_frame_d[WIDTH]   = (^bus.PDin) ^ ODD;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            tx_state_q <= TX_IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            sc_q       <= 1'b0;
            sd_q       <= 1'b1;
            busy_q     <= 1'b0;
            tx_sh_q    <= '1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (bus.Send) begin
                        tx_sh_q    <= tx_frame_d;
                        sd_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        div_q      <= '0;
                        bit_q      <= '0;
                        sc_q       <= 1'b0;
                        tx_state_q <= TX_SHIFT;
                    end
                end
                TX_SHIFT: begin
                    if (div_q == DIV_W'(CLK_DIV - 1)) begin
                        div_q <= '0;
                        if (!sc_q) begin
                            sc_q <= 1'b1;
                        end else begin
                            // Falling SCout edge ends the cell; next bit goes out on the same edge.
                            sc_q <= 1'b0;
                            if (bit_q == TXC_W'(NB - 1)) begin
                                sd_q       <= 1'b1;
                                busy_q     <= 1'b0;
                                tx_state_q <= TX_IDLE;
                            end else begin
                                sd_q    <= tx_sh_q[0];
                                tx_sh_q <= {1'b1, tx_sh_q[NB-2:1]};
                                bit_q   <= bit_q + 1'b1;
                            end
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign bus.SCout  = sc_q;
    assign bus.SDout  = sd_q;
    assign bus.TxBusy = busy_q;

    rx_state_t        rx_state_q;
    logic             sc_s1_q, sc_s2_q, sc_s3_q;
    logic             sd_s1_q, sd_s2_q;
    logic             strobe_q;
    logic             sd_smp_q;
    logic [RXC_W-1:0] rx_cnt_q;
    logic [WIDTH-1:0] rx_data_q;
    logic             rx_par_q;
    logic [WIDTH-1:0] pdout_q;
    logic             ready_q;
    logic             parerr_q;
    logic             frmerr_q;
    logic [WIDTH:0]   rx_shift_d;

    assign rx_shift_d = {sd_smp_q, rx_data_q};

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sc_s1_q    <= 1'b0;
            sc_s2_q    <= 1'b0;
            sc_s3_q    <= 1'b0;
            sd_s1_q    <= 1'b1;
            sd_s2_q    <= 1'b1;
            strobe_q   <= 1'b0;
            sd_smp_q   <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_data_q  <= '0;
            rx_par_q   <= 1'b0;
            pdout_q    <= '0;
            ready_q    <= 1'b0;
            parerr_q   <= 1'b0;
            frmerr_q   <= 1'b0;
        end else begin
            sc_s1_q  <= bus.SCin;
            sc_s2_q  <= sc_s1_q;
            sc_s3_q  <= sc_s2_q;
            sd_s1_q  <= bus.SDin;
            sd_s2_q  <= sd_s1_q;
            // Strobe and its data bit are registered together so they stay aligned.
            strobe_q <= sc_s2_q & ~sc_s3_q;
            sd_smp_q <= sd_s2_q;
            ready_q  <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (strobe_q && !sd_smp_q) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_RECV;
                    end
                end
                RX_RECV: begin
                    if (strobe_q) begin
                        if (rx_cnt_q < RXC_W'(WIDTH)) begin
                            rx_data_q <= rx_shift_d[WIDTH:1];
                            rx_cnt_q  <= rx_cnt_q + 1'b1;
                        end else if ((PARITY_EN != 0) && (rx_cnt_q == RXC_W'(WIDTH))) begin
                            rx_par_q  <= sd_smp_q;
                            rx_cnt_q  <= rx_cnt_q + 1'b1;
                        end else begin
                            pdout_q    <= rx_data_q;
                            parerr_q   <= (PARITY_EN != 0) && (rx_par_q != ((^rx_data_q) ^ ODD));
                            frmerr_q   <= ~sd_smp_q;
                            ready_q    <= 1'b1;
                            rx_state_q <= RX_IDLE;
                        end
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign bus.PDout  = pdout_q;
    assign bus.ready  = ready_q;
    assign bus.ParErr = parerr_q;
    assign bus.FrmErr = frmerr_q;
endmodule

// File: tb/tb_serial_link_txrx.sv
// tb/tb_serial_link_txrx.sv - self-checking bench for serial_link_txrx (loopback, injected frames, reset abort)
module tb_serial_link_txrx;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_link_txrx_if #(.WIDTH(8))  b1();
    serial_link_txrx_if #(.WIDTH(16)) b2();

    logic loop, man_sc, man_sd;
    assign b1.SCin = loop ? b1.SCout : man_sc;
    assign b1.SDin = loop ? b1.SDout : man_sd;
    assign b2.SCin = b2.SCout;
    assign b2.SDin = b2.SDout;

    serial_link_txrx #(.WIDTH(8), .CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(0)) u_dut8 (
        .Clk(clk), .Rst(rst), .bus(b1.slave)
    );
    serial_link_txrx #(.WIDTH(16), .CLK_DIV(4), .PARITY_EN(0), .PARITY_ODD(0)) u_dut16 (
        .Clk(clk), .Rst(rst), .bus(b2.slave)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    typedef struct {
        bit         manual;
        logic [7:0] d;
        bit         bad_par;
        bit         stop;
        bit         exp_pe;
        bit         exp_fe;
    } vec_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   rdy_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d  = d;
        e.pe = pe;
        e.fe = fe;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_send(input logic [7:0] d);
        int n = 0;
        while (b1.TxBusy && n < 300) begin
            tick();
            n++;
        end
        b1.Send = 1'b1;
        b1.PDin = d;
        tick();
        b1.Send = 1'b0;
        check("accept_busy", b1.TxBusy, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        check("drain_timeout", q.size(), 0);
        q.delete();
    endtask

    task automatic drive_bit(input logic b);
        man_sd = b;
        man_sc = 1'b0;
        repeat (4) tick();
        man_sc = 1'b1;
        repeat (4) tick();
        man_sc = 1'b0;
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic parbit, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(parbit);
        drive_bit(stop);
        man_sd = 1'b1;
        repeat (12) tick();
    endtask

    vec_t vt[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int         base, n, gap, nbits, busy_n;
        logic       prev_sc;
        logic [10:0] frame;
        exp_t       e;

        vt[0] = '{0, 8'h00, 0, 1, 0, 0};
        vt[1] = '{0, 8'hFF, 0, 1, 0, 0};
        vt[2] = '{0, 8'h80, 0, 1, 0, 0};
        vt[3] = '{1, 8'h07, 1, 1, 1, 0};
        vt[4] = '{1, 8'h42, 0, 0, 0, 1};
        vt[5] = '{1, 8'hC6, 0, 1, 0, 0};
        vt[6] = '{1, 8'h5B, 1, 0, 1, 1};

        rst = 1'b1; loop = 1'b1; man_sc = 1'b0; man_sd = 1'b1;
        b1.Send = 1'b0; b1.PDin = '0; b2.Send = 1'b0; b2.PDin = '0;

        fork
            begin
                logic prev_rdy = 1'b0;
                forever begin
                    @(negedge clk);
                    if (b1.ready === 1'b1) begin
                        rdy_cnt++;
                        check("ready_width", {31'b0, prev_rdy}, 0);
                        if (q.size() == 0) begin
                            check("unexpected_ready_pdout", {24'b0, b1.PDout}, 32'hFFFF_FFFF);
                        end else begin
                            e = q.pop_front();
                            check("rx_pdout", {24'b0, b1.PDout}, {24'b0, e.d});
                            check("rx_parerr", b1.ParErr, e.pe);
                            check("rx_frmerr", b1.FrmErr, e.fe);
                        end
                    end
                    prev_rdy = b1.ready;
                end
            end
        join_none

        repeat (3) tick();
        check("rst_scout", b1.SCout, 0);
        check("rst_sdout", b1.SDout, 1);
        check("rst_txbusy", b1.TxBusy, 0);
        check("rst_pdout", b1.PDout, 0);
        check("rst_ready", b1.ready, 0);
        check("rst_parerr", b1.ParErr, 0);
        check("rst_frmerr", b1.FrmErr, 0);
        rst = 1'b0;
        tick();

        // Single frame: busy length and on-wire bit order.
        do_send(8'hA5);
        q.push_back(mk(8'hA5, 1'b0, 1'b0));
        busy_n = 0; nbits = 0; frame = '0; prev_sc = b1.SCout;
        while (b1.TxBusy && busy_n < 300) begin
            tick();
            busy_n++;
            if (b1.SCout && !prev_sc) begin
                if (nbits < 11) frame[nbits] = b1.SDout;
                nbits++;
            end
            prev_sc = b1.SCout;
        end
        check("t1_busy_cycles", busy_n, 88);
        check("t1_nbits", nbits, 11);
        check("t1_frame", {21'b0, frame}, {21'b0, 1'b1, 1'b0, 8'hA5, 1'b0});
        check("t1_parity_bit", frame[9], 0);
        wait_drain();

        // Send during busy is dropped.
        base = rdy_cnt;
        do_send(8'h01);
        q.push_back(mk(8'h01, 1'b0, 1'b0));
        repeat (10) tick();
        b1.Send = 1'b1; b1.PDin = 8'hFF;
        tick();
        b1.Send = 1'b0;
        wait_drain();
        repeat (120) tick();
        check("t2_ready_count", rdy_cnt - base, 1);

        // Send held high: back-to-back frames with a one-cycle gap.
        base = rdy_cnt;
        b1.Send = 1'b1; b1.PDin = 8'h3C;
        tick();
        q.push_back(mk(8'h3C, 1'b0, 1'b0));
        b1.PDin = 8'hC3;
        n = 0;
        while (b1.TxBusy && n < 300) begin tick(); n++; end
        gap = 0;
        while (!b1.TxBusy && gap < 10) begin tick(); gap++; end
        b1.Send = 1'b0;
        q.push_back(mk(8'hC3, 1'b0, 1'b0));
        check("t3_gap", gap, 1);
        wait_drain();
        check("t3_ready_count", rdy_cnt - base, 2);

        // Table: loopback and bench-driven frames with parity/framing faults.
        for (int i = 0; i < 7; i++) begin
            q.push_back(mk(vt[i].d, vt[i].exp_pe, vt[i].exp_fe));
            if (vt[i].manual) begin
                loop = 1'b0;
                drive_frame(vt[i].d, (^vt[i].d) ^ vt[i].bad_par, vt[i].stop);
                loop = 1'b1;
            end else begin
                do_send(vt[i].d);
            end
            wait_drain();
        end

        // Reset mid-frame aborts Tx and drops the partial Rx word.
        do_send(8'hE7);
        repeat (36) tick();
        rst = 1'b1;
        tick();
        check("t5_scout", b1.SCout, 0);
        check("t5_sdout", b1.SDout, 1);
        check("t5_txbusy", b1.TxBusy, 0);
        check("t5_ready", b1.ready, 0);
        rst = 1'b0;
        base = rdy_cnt;
        repeat (120) tick();
        check("t5_no_ready", rdy_cnt - base, 0);
        do_send(8'h5A);
        q.push_back(mk(8'h5A, 1'b0, 1'b0));
        wait_drain();

        // 16-bit, no parity instance.
        b2.Send = 1'b1; b2.PDin = 16'hBEEF;
        tick();
        b2.Send = 1'b0;
        n = 0;
        while (b2.TxBusy && n < 400) begin tick(); n++; end
        check("t6_busy_cycles", n, 144);
        n = 0;
        while (!b2.ready && n < 50) begin tick(); n++; end
        check("t6_ready", b2.ready, 1);
        check("t6_pdout", {16'b0, b2.PDout}, 32'h0000_BEEF);
        check("t6_parerr", b2.ParErr, 0);
        check("t6_frmerr", b2.FrmErr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
